ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit for the multicycle core. Consumer of the registered next-PC.
- Takes the committed next PC, issues one AXI4-Lite-style read (AR/R) to instruction memory, and presents the fetched instruction plus its PC to the decoder over a valid/ready handshake.
- At most one fetch is in flight. A new PC is accepted only when the unit is idle.

Parameters:
- RESET_PC, 32'h8000_0000, address of the first fetch after reset.
- TIMEOUT, 255, maximum cycles spent in WAIT before the fetch is abandoned with an error (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc_in  in  32  next PC from next-PC logic
- pc_valid  in  1  pc_in is valid; accepted when pc_valid && pc_ready
- pc_ready  out  1  high only in IDLE
- araddr  out  32  read address
- arvalid  out  1  read-address valid
- arready  in  1  memory accepts address
- rdata  in  32  read data
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error
- rvalid  in  1  read data valid
- rready  out  1  high only in WAIT
- inst  out  32  fetched instruction
- inst_pc  out  32  PC of inst
- inst_valid  out  1  high only in OUT
- inst_ready  in  1  decoder accepts inst
- fetch_err  out  1  qualified by inst_valid; misaligned PC, bad rresp, or timeout
- fetch_cnt  out  32  count of completed decoder handshakes

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - State goes to REQ, pc_r = RESET_PC. No pc_valid is needed for the first fetch.
  - arvalid=0 on the reset cycle. inst=0, inst_pc=0, fetch_err=0, fetch_cnt=0.
  - Timeout counter clears. Reset mid-operation aborts any transaction without draining; the memory slave shares the same reset.
- States: IDLE, REQ, WAIT, OUT.
- IDLE:
  - pc_ready=1.
  - On pc_valid: latch pc_r = pc_in.
  - If pc_in[1:0] != 0, go to OUT with inst=32'h0000_0013 (NOP), fetch_err=1, and no bus access. Otherwise go to REQ.
- REQ:
  - arvalid=1, araddr=pc_r.
  - araddr is held stable until arready; arvalid is never dropped before arready.
  - On arready: go to WAIT and clear the timeout counter.
- WAIT:
  - rready=1. The counter increments each cycle without rvalid.
  - On rvalid: inst=rdata, fetch_err=(rresp!=0), go to OUT.
  - If rvalid and counter==TIMEOUT occur on the same cycle, rvalid wins.
  - On counter==TIMEOUT without rvalid: inst=NOP, fetch_err=1, go to OUT. A late R beat arriving in any later state is ignored, since rready=0 outside WAIT.
- OUT:
  - inst_valid=1, inst_pc=pc_r. inst, inst_pc and fetch_err are held stable until inst_ready.
  - On inst_ready: fetch_cnt += 1 (wraps at 2^32), go to IDLE.
- Minimum latency from pc accept to inst_valid: 3 cycles (IDLE→REQ→WAIT→OUT) with arready and rvalid both high at first opportunity.
- pc_valid outside IDLE is ignored, not queued. The producer must hold it until pc_ready.
- Outputs arvalid, rready, inst_valid and pc_ready are decoded from registered state only; there are no combinational paths from any input.

Decomposition:
- Package ifu_pkg:
  - state enum ifu_state_t {IDLE, REQ, WAIT, OUT}
  - localparam NOP_INST = 32'h0000_0013
  - RESP_OKAY = 2'b00
  - default RESET_PC
- Single module; no sub-module needed. The timeout counter stays inline.

Test Plan:
- Release rst, arready=1, rvalid next cycle with rdata=32'h0010_0093 → araddr=32'h8000_0000; inst=32'h0010_0093, inst_pc=32'h8000_0000, fetch_err=0; inst_valid rises 2 cycles after arvalid first seen.
- pc_in=32'h8000_0010 with arready delayed 4 cycles → araddr stable for all 5 cycles; rdata=32'hdead_beef with rresp=2'b10 → inst=32'hdead_beef, fetch_err=1.
- pc_in=32'h8000_0002 → no arvalid; inst=NOP, fetch_err=1, inst_pc=32'h8000_0002, inst_valid 1 cycle after accept.
- Hold inst_ready=0 for 6 cycles in OUT, toggle pc_valid → inst stable, pc_ready=0, pc ignored; inst_ready=1 → fetch_cnt increments by exactly 1.
- TIMEOUT=4, rvalid never asserted → after 5 WAIT cycles inst=NOP, fetch_err=1; rvalid pulse afterwards → no state change.
- Assert rst while in WAIT → next cycle state REQ, arvalid asserted with araddr=32'h8000_0000, fetch_cnt=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} ifu_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// AXI4-Lite read channel (AR/R) between the fetch unit and instruction memory.
interface ifu_fetch_if;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: next PC in, one AR/R read, instruction
// plus PC out to the decoder. All handshake outputs come from registers only.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc_in,
   input  logic               pc_valid,
   output logic               pc_ready,
   ifu_fetch_if.master        mem,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic               fetch_err,
   output logic [31:0]        fetch_cnt
);

   localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

   ifu_state_t  state, state_n;
   logic [31:0] pc_r;
   logic        arvalid_r;
   logic [7:0]  to_cnt;

   assign pc_ready    = (state == IDLE);
   assign mem.rready  = (state == WAIT);
   assign inst_valid  = (state == OUT);
   assign mem.arvalid = arvalid_r;
   assign mem.araddr  = pc_r;

   always_ff @(posedge clk) begin
      if (rst) state <= REQ;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (pc_valid)                  state_n = (pc_in[1:0] != 2'b00) ? OUT : REQ;
         REQ:  if (arvalid_r && mem.arready)  state_n = WAIT;
         WAIT: if (mem.rvalid || to_cnt == TO_MAX) state_n = OUT;
         OUT:  if (inst_ready)                state_n = IDLE;
         default:                             state_n = IDLE;
      endcase
   end

   // arvalid is registered off the next state so it stays low on the reset cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r      <= RESET_PC;
         arvalid_r <= 1'b0;
         to_cnt    <= '0;
         inst      <= '0;
         inst_pc   <= '0;
         fetch_err <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         arvalid_r <= (state_n == REQ);
         case (state)
            IDLE: if (pc_valid) begin
               pc_r <= pc_in;
               if (pc_in[1:0] != 2'b00) begin
                  inst      <= NOP_INST;
                  inst_pc   <= pc_in;
                  fetch_err <= 1'b1;
               end
            end
            REQ: if (arvalid_r && mem.arready) to_cnt <= '0;
            WAIT: begin
               // a beat landing on the timeout cycle still counts as data
               if (mem.rvalid) begin
                  inst      <= mem.rdata;
                  inst_pc   <= pc_r;
                  fetch_err <= (mem.rresp != RESP_OKAY);
               end else if (to_cnt == TO_MAX) begin
                  inst      <= NOP_INST;
                  inst_pc   <= pc_r;
                  fetch_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            OUT: if (inst_ready) fetch_cnt <= fetch_cnt + 32'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: bus-side responder tasks and a scoreboard queue
// of expected decoder outputs, checked with immediate assertions.
module tb_ifu_fetch;
   import ifu_pkg::*;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;
   exp_t sb[$];

   ifu_fetch_if bus();

   ifu_fetch #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .mem        (bus.master),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .fetch_err  (fetch_err),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] p, input logic e);
      exp_t x;
      x.inst = i; x.pc = p; x.err = e;
      sb.push_back(x);
   endtask

   task automatic accept(input logic [31:0] pc);
      chk("pc_ready_idle", pc_ready, 1);
      pc_in = pc; pc_valid = 1'b1;
      @(negedge clk);
      pc_valid = 1'b0;
   endtask

   // Memory responder: arready after ar_dly cycles, rvalid after r_dly WAIT cycles
   task automatic run_bus(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input logic [31:0] d, input logic [1:0] resp, input bit give_r,
                          output int wc, output int edges);
      int n = 0;
      edges = 0;
      while (!bus.arvalid && n < 20) begin @(negedge clk); n++; end
      chk("arvalid_seen", bus.arvalid, 1);
      for (int i = 0; i <= ar_dly; i++) begin
         chk("araddr_stable", bus.araddr, addr);
         chk("arvalid_held", bus.arvalid, 1);
         if (i == ar_dly) bus.arready = 1'b1;
         @(negedge clk); edges++;
         bus.arready = 1'b0;
      end
      wc = 0;
      while (bus.rready && wc < 300) begin
         if (give_r && wc == r_dly) begin
            bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = resp;
         end
         @(negedge clk); edges++;
         bus.rvalid = 1'b0;
         wc++;
      end
   endtask

   task automatic consume();
      exp_t e;
      int   n = 0;
      while (!inst_valid && n < 300) begin @(negedge clk); n++; end
      chk("inst_valid_seen", inst_valid, 1);
      chk("sb_size", 32'(sb.size()), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("inst", inst, e.inst);
         chk("inst_pc", inst_pc, e.pc);
         chk("fetch_err", fetch_err, e.err);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      exp_cnt++;
      chk("fetch_cnt", fetch_cnt, exp_cnt);
      chk("idle_after_out", pc_ready, 1);
      chk("inst_valid_drop", inst_valid, 0);
   endtask

   initial begin
      int wc, edges;
      rst = 1'b1; pc_in = '0; pc_valid = 1'b0; inst_ready = 1'b0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
      repeat (2) @(negedge clk);

      chk("rst_arvalid", bus.arvalid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_fetch_cnt", fetch_cnt, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_pc_ready", pc_ready, 0);

      // first fetch from RESET_PC without pc_valid
      push(32'h0010_0093, 32'h8000_0000, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      run_bus(32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 1'b1, wc, edges);
      chk("first_latency", 32'(edges), 2);
      consume();

      // delayed arready, error response
      push(32'hdead_beef, 32'h8000_0010, 1'b1);
      accept(32'h8000_0010);
      run_bus(32'h8000_0010, 4, 1, 32'hdead_beef, 2'b10, 1'b1, wc, edges);
      consume();

      // misaligned PC: no bus access, decoder stalls while pc_valid toggles
      push(NOP_INST, 32'h8000_0002, 1'b1);
      accept(32'h8000_0002);
      chk("misalign_inst_valid", inst_valid, 1);
      chk("misalign_no_ar", bus.arvalid, 0);
      for (int i = 0; i < 6; i++) begin
         pc_in = 32'h8000_0100; pc_valid = ~pc_valid;
         @(negedge clk);
         chk("stall_inst", inst, NOP_INST);
         chk("stall_inst_pc", inst_pc, 32'h8000_0002);
         chk("stall_pc_ready", pc_ready, 0);
      end
      pc_valid = 1'b0;
      consume();

      // timeout: 5 WAIT cycles, then a late beat is ignored
      push(NOP_INST, 32'h8000_0020, 1'b1);
      accept(32'h8000_0020);
      run_bus(32'h8000_0020, 0, 0, 32'h0, 2'b00, 1'b0, wc, edges);
      chk("timeout_wait_cycles", 32'(wc), 5);
      bus.rvalid = 1'b1; bus.rdata = 32'hffff_ffff; bus.rresp = 2'b00;
      @(negedge clk);
      bus.rvalid = 1'b0;
      chk("late_beat_still_out", inst_valid, 1);
      consume();

      // beat on the timeout cycle wins
      push(32'h1234_5678, 32'h8000_0030, 1'b0);
      accept(32'h8000_0030);
      run_bus(32'h8000_0030, 0, 4, 32'h1234_5678, 2'b00, 1'b1, wc, edges);
      chk("edge_wait_cycles", 32'(wc), 5);
      consume();

      // reset while in WAIT
      accept(32'h8000_0040);
      chk("pre_rst_arvalid", bus.arvalid, 1);
      bus.arready = 1'b1;
      @(negedge clk);
      bus.arready = 1'b0;
      chk("pre_rst_wait", bus.rready, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      chk("midrst_arvalid", bus.arvalid, 0);
      chk("midrst_rready", bus.rready, 0);
      chk("midrst_fetch_cnt", fetch_cnt, 0);
      chk("midrst_inst", inst, 0);
      @(negedge clk);
      chk("post_rst_arvalid", bus.arvalid, 1);
      chk("post_rst_araddr", bus.araddr, 32'h8000_0000);
      push(32'hcafe_f00d, 32'h8000_0000, 1'b0);
      run_bus(32'h8000_0000, 1, 2, 32'hcafe_f00d, 2'b00, 1'b1, wc, edges);
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
